counter_sweep_ctrl: RTL and testbench
=====================================

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of count, bounds and load value.
REQ-002 Parameter SW_W, default 4: width of the sweep-count input and internal sweep counter.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port start  in  1: one-cycle request to begin a sweep program; sampled only in IDLE.
REQ-006 Port abort  in  1: terminate any active program.
REQ-007 Port lo_val  in  WIDTH: lower turning point; captured on accepted start.
REQ-008 Port hi_val  in  WIDTH: upper turning point; captured on accepted start.
REQ-009 Port sweeps  in  SW_W: number of up-then-down sweeps; captured on accepted start.
REQ-010 Port count  in  WIDTH: registered count fed back from up_down_counter.
REQ-011 Port enable  out  1: counter enable.
REQ-012 Port up_down  out  1: counter direction, 1=up, 0=down.
REQ-013 Port load  out  1: counter synchronous load strobe.
REQ-014 Port load_val  out  WIDTH: counter load value.
REQ-015 Port busy  out  1: high in every state except IDLE.
REQ-016 Port done  out  1: one-cycle pulse on normal completion.
REQ-017 Port err  out  1: one-cycle pulse on a rejected start.

Function
REQ-018 The counter loads load_val when load=1 and steps by 1 per cycle when enable=1; the controller relies on this contract.
REQ-019 FSM states SHALL be IDLE, LOAD, UP, DOWN and DONE.
REQ-020 IDLE: outputs enable, load and up_down are 0; start=1 with lo_val<hi_val and sweeps!=0 captures lo_q, hi_q and rem=sweeps, then goes to LOAD.
REQ-021 IDLE: start=1 with lo_val>=hi_val or sweeps==0 pulses err the next cycle and stays IDLE, capturing nothing.
REQ-022 LOAD lasts exactly one cycle with load=1, load_val=lo_q and enable=0, then goes to UP.
REQ-023 load_val SHALL equal lo_q in every state.
REQ-024 UP with count!=hi_q: enable=1, up_down=1, stay in UP.
REQ-025 UP with count==hi_q: enable=1, up_down=0 (Mealy turn, no dwell), go to DOWN.
REQ-026 DOWN with count!=lo_q: enable=1, up_down=0, stay in DOWN.
REQ-027 DOWN with count==lo_q and rem>1: decrement rem, drive enable=1 and up_down=1, go to UP.
REQ-028 DOWN with count==lo_q and rem==1: enable=0, go to DONE.
REQ-029 DONE lasts one cycle with done=1 and enable=0, then goes to IDLE.
REQ-030 The cycle count from LOAD entry to DONE entry SHALL be exactly 1 + sweeps*(2*(hi_q-lo_q)) + 1.
REQ-031 abort=1 in any non-IDLE state forces IDLE next cycle with enable=0, load=0 and no done pulse; abort in IDLE is ignored.
REQ-032 abort SHALL take priority over every FSM transition, including start.
REQ-033 start SHALL be ignored while busy=1.
REQ-034 Bound comparisons SHALL be unsigned WIDTH-bit; hi_q=2^WIDTH-1 and lo_q=0 are legal, and the counter never wraps.

Reset
REQ-035 reset=1 at a clock edge forces IDLE and clears lo_q, hi_q and rem.
REQ-036 During and after reset, enable, up_down, load, load_val, busy, done and err SHALL all be 0.
REQ-037 reset overrides abort and start and SHALL take effect in any state, mid-sweep included.

Configuration
REQ-038 With SWEEP_PAUSE_EN defined, an input port pause (1 bit) SHALL exist.
REQ-039 With SWEEP_PAUSE_EN, pause=1 in UP or DOWN forces enable=0 and freezes state and rem; pause is ignored in other states, and abort still wins.
REQ-040 Without SWEEP_PAUSE_EN the pause port and its logic SHALL be absent, and behaviour matches REQ-024..REQ-028.

Verification
REQ-041 lo=2, hi=5, sweeps=1, start -> count 2,3,4,5,4,3,2; done pulses 8 cycles after LOAD entry; busy then drops.
REQ-042 lo=0, hi=15, sweeps=2 -> two full triangles with no wrap past 15 or 0; done after 62 cycles.
REQ-043 start with lo=7, hi=7 and again with sweeps=0 -> err pulse each time, busy stays 0, no load.
REQ-044 abort at count=4 while in UP (lo=1, hi=9) -> next cycle IDLE, enable=0, no done; a new start is then accepted.
REQ-045 reset asserted in DOWN -> next cycle all outputs 0; start while busy is ignored.
REQ-046 With SWEEP_PAUSE_EN, pause held 3 cycles at count=3 -> count holds at 3 for 3 cycles; done is delayed exactly 3 cycles.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - triangle sweep sequencer driving an external loadable up/down counter
// Define SWEEP_PAUSE_EN to add a pause input that freezes an active sweep.
module counter_sweep_ctrl #(
   parameter int WIDTH = 4,
   parameter int SW_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
`ifdef SWEEP_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [WIDTH-1:0] lo_val,
   input  logic [WIDTH-1:0] hi_val,
   input  logic [SW_W-1:0]  sweeps,
   input  logic [WIDTH-1:0] count,
   output logic             enable,
   output logic             up_down,
   output logic             load,
   output logic [WIDTH-1:0] load_val,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic [SW_W-1:0]  rem, rem_n;
   logic             err_q, err_n;
   logic             capture;
   logic             hold;

`ifdef SWEEP_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         lo_q  <= '0;
         hi_q  <= '0;
         rem   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
         err_q <= err_n;
         if (capture) begin
            lo_q <= lo_val;
            hi_q <= hi_val;
         end
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      err_n   = 1'b0;
      capture = 1'b0;
      enable  = 1'b0;
      up_down = 1'b0;
      load    = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if ((lo_val < hi_val) && (sweeps != '0)) begin
                  capture = 1'b1;
                  rem_n   = sweeps;
                  state_n = LOAD;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         LOAD: begin
            load    = 1'b1;
            state_n = UP;
         end
         UP: begin
            if (!hold) begin
               enable = 1'b1;
               // Turn at the top without a dwell cycle: the last up step and the first down step are adjacent.
               if (count == hi_q) begin
                  up_down = 1'b0;
                  state_n = DOWN;
               end else begin
                  up_down = 1'b1;
               end
            end
         end
         DOWN: begin
            if (!hold) begin
               if (count != lo_q) begin
                  enable = 1'b1;
               end else if (rem > SW_W'(1)) begin
                  enable  = 1'b1;
                  up_down = 1'b1;
                  rem_n   = rem - SW_W'(1);
                  state_n = UP;
               end else begin
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         state_n = IDLE;
         rem_n   = rem;
         enable  = 1'b0;
         up_down = 1'b0;
         load    = 1'b0;
         done    = 1'b0;
      end
      // Reset is synchronous, but outputs are silenced in the reset cycle itself as well.
      if (reset) begin
         enable  = 1'b0;
         up_down = 1'b0;
         load    = 1'b0;
         done    = 1'b0;
      end
   end

   assign busy     = (state != IDLE) && !reset;
   assign err      = err_q && !reset;
   assign load_val = reset ? '0 : lo_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - scoreboard bench for counter_sweep_ctrl with a behavioural counter and sweep model
module tb_counter_sweep_ctrl;

   localparam int WIDTH = 4;
   localparam int SW_W  = 4;

   typedef struct {
      int kind;
      int at;
      int len;
   } ev_t;

   logic             clk = 1'b0;
   logic             reset, start, abort;
`ifdef SWEEP_PAUSE_EN
   logic             pause;
`endif
   logic [WIDTH-1:0] lo_val, hi_val, count, load_val;
   logic [SW_W-1:0]  sweeps;
   logic             enable, up_down, load, busy, done, err;

   int   cyc = 0;
   int   n_total = 0;
   int   n_bad = 0;
   bit   mon_on = 1'b0;
   ev_t  ev_q[$];
   int   trace_q[$];
   int   seen[$];
   ev_t  cur;
   int   xv;

   counter_sweep_ctrl #(.WIDTH(WIDTH), .SW_W(SW_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef SWEEP_PAUSE_EN
      .pause(pause),
`endif
      .lo_val(lo_val), .hi_val(hi_val), .sweeps(sweeps), .count(count),
      .enable(enable), .up_down(up_down), .load(load), .load_val(load_val),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (reset)       count <= '0;
      else if (load)   count <= load_val;
      else if (enable) count <= up_down ? count + 1'b1 : count - 1'b1;
   end

   task automatic check(string name, int act, int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(string name, string what);
      n_total++;
      n_bad++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Expected counter trace: lo, then per sweep lo+1..hi and hi-1..lo, then lo held in DONE.
   function automatic int push_trace(int lo, int hi, int s, int pv, int np);
      int n = 0;
      trace_q.push_back(lo); n++;
      for (int k = 0; k < s; k++) begin
         for (int v = lo + 1; v <= hi; v++) begin
            trace_q.push_back(v); n++;
            if (k == 0 && v == pv) begin
               for (int r = 0; r < np; r++) begin trace_q.push_back(v); n++; end
            end
         end
         for (int v = hi - 1; v >= lo; v--) begin trace_q.push_back(v); n++; end
      end
      trace_q.push_back(lo); n++;
      return n;
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         if (!busy) begin
            check("idle_enable", int'(enable), 0);
            check("idle_load", int'(load), 0);
            check("idle_up_down", int'(up_down), 0);
            seen.delete();
         end else if (!load) begin
            seen.push_back(int'(count));
         end
         if (err || done) begin
            if (ev_q.size() == 0) begin
               fail_msg("unexpected_event", done ? "got done, expected none" : "got err, expected none");
            end else begin
               cur = ev_q.pop_front();
               check("event_kind", done ? 1 : 0, cur.kind);
               check("event_cycle", cyc, cur.at);
               if (cur.kind == 1) begin
                  check("trace_len", seen.size(), cur.len);
                  for (int i = 0; i < cur.len; i++) begin
                     if (trace_q.size() != 0) begin
                        xv = trace_q.pop_front();
                        if (i < seen.size()) check("trace_val", seen[i], xv);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic run_prog(int lo, int hi, int s, int pv, int np);
      ev_t e;
      @(negedge clk);
      lo_val = WIDTH'(lo);
      hi_val = WIDTH'(hi);
      sweeps = SW_W'(s);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (lo < hi && s != 0) begin
         e.kind = 1;
         e.at   = cyc + 2 + 2 * s * (hi - lo) + np;
         e.len  = push_trace(lo, hi, s, pv, np);
      end else begin
         e.kind = 0;
         e.at   = cyc;
         e.len  = 0;
      end
      ev_q.push_back(e);
   endtask

   task automatic wait_quiet(string name, int budget);
      int n = 0;
      while ((ev_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= budget) begin
         fail_msg(name, "timed out waiting for expected event");
         ev_q.delete();
         trace_q.delete();
      end
   endtask

   task automatic wait_state(string name, int want_cnt, bit want_up);
      int n = 0;
      while (!(busy && enable && up_down == want_up && (want_cnt < 0 || int'(count) == want_cnt)) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 300) fail_msg(name, "timed out waiting for sweep position");
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_enable"}, int'(enable), 0);
      check({tag, "_up_down"}, int'(up_down), 0);
      check({tag, "_load"}, int'(load), 0);
      check({tag, "_load_val"}, int'(load_val), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_err"}, int'(err), 0);
   endtask

   initial begin
      int lo, hi, s, t;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef SWEEP_PAUSE_EN
      pause = 1'b0;
`endif
      lo_val = '0; hi_val = '0; sweeps = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      mon_on = 1'b1;

      run_prog(2, 5, 1, -1, 0);
      wait_quiet("basic_2_5", 200);

      run_prog(0, 15, 2, -1, 0);
      wait_quiet("full_range", 200);

      run_prog(7, 7, 1, -1, 0);
      wait_quiet("reject_equal", 20);
      run_prog(3, 9, 0, -1, 0);
      wait_quiet("reject_zero_sweeps", 20);

      // Abort mid-UP, then a fresh program must still be accepted.
      run_prog(1, 9, 1, -1, 0);
      wait_state("abort_wait", 4, 1'b1);
      abort = 1'b1;
      #1;
      check("abort_enable", int'(enable), 0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      ev_q.delete();
      trace_q.delete();
      @(negedge clk);
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_enable_after", int'(enable), 0);
      run_prog(1, 9, 1, -1, 0);
      wait_quiet("after_abort", 200);

      // Start while busy is ignored; reset in DOWN silences everything.
      run_prog(2, 8, 1, -1, 0);
      @(negedge clk);
      lo_val = 4'd0; hi_val = 4'd3; sweeps = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_state("reset_wait", -1, 1'b0);
      reset = 1'b1;
      #1;
      check_all_zero("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      ev_q.delete();
      trace_q.delete();
      @(negedge clk);
      #1;
      check_all_zero("post_reset");
      check("post_reset_count", int'(count), 0);

      run_prog(3, 6, 2, -1, 0);
      @(negedge clk);
      @(negedge clk);
      lo_val = 4'd0; hi_val = 4'd15; sweeps = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_quiet("start_while_busy", 200);

`ifdef SWEEP_PAUSE_EN
      run_prog(1, 6, 1, 3, 3);
      wait_state("pause_wait", 3, 1'b1);
      pause = 1'b1;
      #1;
      check("pause_enable", int'(enable), 0);
      repeat (3) @(negedge clk);
      #1;
      pause = 1'b0;
      wait_quiet("pause", 200);
`endif

      for (int i = 0; i < 40; i++) begin
         lo = $urandom_range(0, 15);
         hi = $urandom_range(0, 15);
         s  = $urandom_range(0, 3);
         if ($urandom_range(0, 4) != 0) begin
            if (lo > hi) begin t = lo; lo = hi; hi = t; end
            if (s == 0) s = 1;
         end
         run_prog(lo, hi, s, -1, 0);
         if (lo < hi && s != 0 && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            lo_val = WIDTH'($urandom_range(0, 7));
            hi_val = WIDTH'($urandom_range(8, 15));
            sweeps = SW_W'($urandom_range(1, 3));
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_quiet("random", 300);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
